snake_game_ctrl: RTL and testbench

- Top-level game sequencer for the snake design; sits between the collision detector and the snake/apple position logic.
- Paces snake movement from the video frame tick and buffers the player's direction.
- Consumes the collision detector's 2-bit state and decides whether the snake grows, the game ends, or play continues.
- Keeps the snake length and score.

---
 rtl/snake_game_ctrl.sv | 116 +++++++++++
 tb/tb_snake_game_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: paces snake moves from frame ticks, buffers direction, resolves collisions into grow/over, tracks length and score.
module snake_game_ctrl #(
  parameter int FRAMES_PER_MOVE = 8,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN = 32,
  parameter int SCORE_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  input  logic [3:0]                     dir_btn_i,
  input  logic                           frame_tick_i,
  input  logic [1:0]                     collision_i,
  output logic                           move_o,
  output logic [1:0]                     dir_o,
  output logic                           grow_o,
  output logic                           apple_respawn_o,
  output logic [$clog2(MAX_LEN+1)-1:0]   snake_len_o,
  output logic [SCORE_W-1:0]             score_o,
  output logic [1:0]                     game_state_o
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = $clog2(FRAMES_PER_MOVE);
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_MOVE - 1);
  localparam logic [LW-1:0] INIT = LW'(INIT_LEN);
  localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, GROW = 2'b10, OVER = 2'b11} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic apple, apple_n, crash, crash_n;
  logic [1:0] dir, dir_n, pend, pend_n;
  logic [LW-1:0] len, len_n;
  logic [SCORE_W-1:0] score, score_n;
  logic move, move_n, grow, grow_n;
  logic run, restart, evt, apple_c, crash_c, legal;
  logic [1:0] btn_dir;
  assign run = state == PLAY || state == GROW;
  assign restart = (state == IDLE || state == OVER) && start_i;
  assign evt = run && frame_tick_i && cnt == LAST;
  // a collision arriving in the move cycle itself still counts toward that move
  assign apple_c = apple || collision_i == 2'b01;
  assign crash_c = crash || collision_i[1];
  assign btn_dir = dir_btn_i[3] ? 2'b00 : dir_btn_i[2] ? 2'b01 : dir_btn_i[1] ? 2'b10 : 2'b11;
  assign legal = |dir_btn_i && btn_dir != (dir ^ 2'b01);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    apple_n = apple;
    crash_n = crash;
    dir_n = dir;
    pend_n = pend;
    len_n = len;
    score_n = score;
    move_n = 1'b0;
    grow_n = 1'b0;
    if (restart) begin
      state_n = PLAY;
      cnt_n = '0;
      apple_n = 1'b0;
      crash_n = 1'b0;
      dir_n = 2'b11;
      pend_n = 2'b11;
      len_n = INIT;
      score_n = '0;
    end else if (run) begin
      state_n = PLAY;
      pend_n = legal ? btn_dir : pend;
      cnt_n = frame_tick_i ? (evt ? '0 : cnt + 1'b1) : cnt;
      apple_n = apple_c && !evt;
      crash_n = crash_c && !evt;
      if (evt && crash_c) state_n = OVER;
      else if (evt) begin
        move_n = 1'b1;
        dir_n = pend_n;
        grow_n = apple_c;
        if (apple_c) begin
          state_n = GROW;
          len_n = len == MAXL ? len : len + 1'b1;
          score_n = &score ? score : score + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      apple <= 1'b0;
      crash <= 1'b0;
      dir <= 2'b11;
      pend <= 2'b11;
      len <= INIT;
      score <= '0;
      move <= 1'b0;
      grow <= 1'b0;
    end else begin
      cnt <= cnt_n;
      apple <= apple_n;
      crash <= crash_n;
      dir <= dir_n;
      pend <= pend_n;
      len <= len_n;
      score <= score_n;
      move <= move_n;
      grow <= grow_n;
    end
  assign move_o = move;
  assign grow_o = grow;
  assign apple_respawn_o = grow;
  assign dir_o = dir;
  assign snake_len_o = len;
  assign score_o = score;
  assign game_state_o = state;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: scoreboard bench; a rule-level game model queues expected outputs per clock, a monitor compares.
module tb_snake_game_ctrl;
  localparam int FPM = 8;
  typedef struct packed {
    logic [1:0] st;
    logic [1:0] dir;
    logic [5:0] len;
    logic [7:0] sc;
    logic [3:0] sc4;
    logic mv;
    logic gr;
    logic ar;
  } exp_t;
  logic clk = 0, reset = 0, start_i = 0, frame_tick_i = 0;
  logic [3:0] dir_btn_i = 0;
  logic [1:0] collision_i = 0;
  logic move_o, grow_o, apple_respawn_o;
  logic [1:0] dir_o, game_state_o;
  logic [5:0] snake_len_o;
  logic [7:0] score_o;
  logic move4, grow4, resp4;
  logic [1:0] dir4, st4;
  logic [5:0] len4;
  logic [3:0] score4;
  always #5 clk = ~clk;
  snake_game_ctrl dut (
    .clk(clk), .reset(reset), .start_i(start_i), .dir_btn_i(dir_btn_i),
    .frame_tick_i(frame_tick_i), .collision_i(collision_i), .move_o(move_o),
    .dir_o(dir_o), .grow_o(grow_o), .apple_respawn_o(apple_respawn_o),
    .snake_len_o(snake_len_o), .score_o(score_o), .game_state_o(game_state_o)
  );
  snake_game_ctrl #(.SCORE_W(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start_i), .dir_btn_i(dir_btn_i),
    .frame_tick_i(frame_tick_i), .collision_i(collision_i), .move_o(move4),
    .dir_o(dir4), .grow_o(grow4), .apple_respawn_o(resp4),
    .snake_len_o(len4), .score_o(score4), .game_state_o(st4)
  );
  int tests = 0, fails = 0;
  int m_st, m_dir, m_pend, m_len, m_sc, m_sc4, m_ticks;
  bit m_apple, m_crash;
  exp_t q[$];
  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction
  function automatic string show(input exp_t e);
    return $sformatf("st=%0d dir=%0d len=%0d sc=%0d sc4=%0d mv=%0b gr=%0b ar=%0b",
                     e.st, e.dir, e.len, e.sc, e.sc4, e.mv, e.gr, e.ar);
  endfunction
  function automatic exp_t actual();
    return {game_state_o, dir_o, snake_len_o, score_o, score4, move_o, grow_o, apple_respawn_o};
  endfunction
  function void m_init();
    m_dir = 3; m_pend = 3; m_len = 3; m_sc = 0; m_sc4 = 0;
    m_ticks = 0; m_apple = 0; m_crash = 0;
  endfunction
  function automatic exp_t model(input bit s, input logic [3:0] b, input bit t, input logic [1:0] c);
    bit mv = 0, gr = 0;
    int bd;
    if (m_st == 0 || m_st == 3) begin
      if (s) begin m_init(); m_st = 1; end
    end else begin
      m_st = 1;
      if (c == 1) m_apple = 1;
      if (c >= 2) m_crash = 1;
      if (b != 0) begin
        bd = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
        if (bd != opposite(m_dir)) m_pend = bd;
      end
      if (t) begin
        m_ticks++;
        if (m_ticks == FPM) begin
          m_ticks = 0;
          if (m_crash) m_st = 3;
          else begin
            mv = 1;
            m_dir = m_pend;
            if (m_apple) begin
              gr = 1; m_st = 2;
              m_len = (m_len + 1 > 32) ? 32 : m_len + 1;
              m_sc = (m_sc + 1 > 255) ? 255 : m_sc + 1;
              m_sc4 = (m_sc4 + 1 > 15) ? 15 : m_sc4 + 1;
            end
          end
          m_apple = 0; m_crash = 0;
        end
      end
    end
    return {2'(m_st), 2'(m_dir), 6'(m_len), 8'(m_sc), 4'(m_sc4), mv, gr, gr};
  endfunction
  task automatic step(input bit s, input logic [3:0] b, input bit t, input logic [1:0] c);
    @(negedge clk);
    start_i = s; dir_btn_i = b; frame_tick_i = t; collision_i = c;
    q.push_back(model(s, b, t, c));
  endtask
  task automatic frame(input logic [1:0] ct, input logic [1:0] c1, input logic [1:0] c2,
                       input logic [3:0] b1, input logic [3:0] b2);
    step(0, 0, 1, ct);
    step(0, b1, 0, c1);
    step(0, b2, 0, c2);
  endtask
  task automatic quiet(input int n);
    repeat (n) frame(0, 0, 0, 0, 0);
  endtask
  task automatic check_reset(input string name);
    exp_t e;
    e = {2'd0, 2'd3, 6'd3, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    tests++;
    if (actual() !== e) begin
      fails++;
      $display("FAIL %s got %s want %s", name, show(actual()), show(e));
    end
  endtask
  function automatic logic [1:0] rcol();
    int r = $urandom_range(0, 999);
    return r < 960 ? 2'd0 : r < 990 ? 2'd1 : r < 995 ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [3:0] rbtn();
    return $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 15)) : 4'd0;
  endfunction
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (actual() !== e) begin
          fails++;
          $display("FAIL cycle @%0t got %s want %s", $time, show(actual()), show(e));
        end
      end
    end
  end
  initial begin : stim
    #2 reset = 1;
    #1 check_reset("reset_initial");
    repeat (2) @(negedge clk);
    reset = 0;
    m_st = 0; m_init();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    quiet(16);
    frame(0, 1, 0, 0, 0);
    quiet(7);
    quiet(1);
    frame(0, 0, 0, 4'b0010, 4'b1000);
    quiet(7);
    frame(0, 0, 0, 4'b0100, 0);
    quiet(7);
    repeat (30) begin
      frame(0, 1, 0, 0, 0);
      quiet(7);
    end
    frame(0, 1, 0, 0, 0);
    frame(0, 0, 2, 0, 0);
    quiet(6);
    frame(3, 1, 2, 4'b1111, 0);
    quiet(10);
    repeat (3) step(1, 0, 0, 0);
    quiet(8);
    frame(3, 0, 0, 0, 0);
    quiet(7);
    step(1, 0, 0, 0);
    quiet(11);
    @(posedge clk);
    #3 reset = 1;
    #1 check_reset("reset_midgame");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    m_st = 0; m_init();
    step(1, 0, 0, 0);
    for (int i = 0; i < 700; i++) begin
      if ((m_st == 3 || m_st == 0) && $urandom_range(0, 3) == 0) step(1, rbtn(), 0, rcol());
      else if ($urandom_range(0, 9) == 0) step($urandom_range(0, 1) == 1, rbtn(), 0, rcol());
      frame(rcol(), rcol(), rcol(), rbtn(), rbtn());
    end
    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
